logic_unit_mc: RTL
==================

// Module: logic_unit_mc
// PURPOSE
//  Next-generation bitwise logic unit for the EX stage: parametrised width, 8 ops, registered output with valid/ready handshake.
//  Bitwise ops complete in 1 cycle; CPOP (population count of A) is iterative, CHUNK bits/cycle, via a small FSM.
//  Sits between the ALU operand muxes and the EX/MEM result path; stalls upstream via o_ready while busy.
// PARAMETERS
//  WIDTH  32  operand/result width in bits (>=8)
//  CHUNK  8   bits of A counted per cycle in CPOP; must divide WIDTH; N = WIDTH/CHUNK
// PORTS
//  i_clk     in   1      clock, all state on rising edge
//  i_reset   in   1      asynchronous, active-low reset
//  i_valid   in   1      request valid
//  o_ready   out  1      unit can accept a request this cycle
//  i_op      in   3      operation select (table below)
//  i_a       in   WIDTH  operand A
//  i_b       in   WIDTH  operand B
//  o_valid   out  1      o_result/o_zero valid
//  i_ready   in   1      consumer accepts result this cycle
//  o_result  out  WIDTH  result
//  o_zero    out  1      1 when o_result == 0
// BEHAVIOUR
//  Ops: 000 XOR a^b | 001 OR a|b | 010 AND a&b | 011 ZERO (const 0) | 100 XNOR ~(a^b) | 101 ORN a|~b | 110 ANDN a&~b
//       111 CPOP = number of 1s in A, zero-extended to WIDTH; B ignored.
//  Encodings 000-011 equal the previous 2-bit unit with i_op[2]=0.
//  Reset (i_reset=0, async): state=IDLE, o_valid=0, o_result=0, o_zero=0 (held low), count/index regs=0; o_ready=1 after release.
//  Accept = i_valid & o_ready at rising edge; op/operands captured only then.
//  o_ready = (state==IDLE) & (!o_valid | i_ready)  -- combinational; low throughout COUNT.
//  Output retire = o_valid & i_ready at edge; o_valid clears unless a new result loads on the same edge.
//  FSM states: IDLE, COUNT.
//   IDLE, accept, op!=111: o_result/o_zero load at that edge, o_valid=1 (latency 1). Stay IDLE.
//   IDLE, accept, op==111: latch A, acc=0, idx=0 -> COUNT.
//   COUNT: each cycle acc += popcount(A[idx*CHUNK +: CHUNK]), idx++. On idx==N-1 edge: o_result=final acc,
//     o_zero=(acc==0), o_valid=1 -> IDLE. o_valid rises N edges after accept edge (N=4 default).
//   COUNT entered only when o_valid is 0 or retiring at the accept edge, so no result is ever overwritten.
//  Back-to-back bitwise ops with i_ready=1: one result per cycle, no bubbles.
//  Backpressure: o_valid=1 & i_ready=0 -> o_result, o_zero, o_valid held stable, o_ready=0, no accept.
//  i_valid while o_ready=0: ignored, not queued; requester must hold request.
//  CPOP of all-ones = WIDTH (fits: WIDTH < 2^WIDTH); acc width = clog2(WIDTH+1), zero-extended.
//  Reset mid-COUNT: partial count discarded, outputs to reset values, IDLE immediately.
//  X on i_op/i_a/i_b when not accepting must not affect state.
// TESTING
//  1 XOR A=F0F0F0F0 B=FF00FF00 -> next edge o_valid=1, o_result=0FF00FF0, o_zero=0.
//  2 op=011 A=FFFFFFFF B=FFFFFFFF -> o_result=00000000, o_zero=1; ANDN A=FFFF0000 B=FF00FF00 -> 00FF0000.
//  3 Stream XOR,OR,AND,XNOR on 4 consecutive cycles, i_ready=1 -> 4 results on 4 consecutive cycles, o_ready always 1.
//  4 Result pending, i_ready=0 for 3 cycles -> o_result stable, o_ready=0, held i_valid not accepted until i_ready=1.
//  5 CPOP A=FFFFFFFF -> o_ready=0 for 4 cycles, o_valid after 4 edges, o_result=00000020; A=0 -> 0, o_zero=1; A=80000001 -> 2.
//  6 i_reset=0 during COUNT cycle 2 -> o_valid=0, o_result=0 asynchronously; after release o_ready=1, new XOR completes normally.

Source files
------------

// File: rtl/logic_unit_mc_if.sv
// ============================================================================
// Module  : logic_unit_mc_if
// Brief   : Request/result handshake bundle for the EX-stage logic unit.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface logic_unit_mc_if #(
  parameter int WIDTH = 32
);
  logic             i_valid;
  logic             o_ready;
  logic [2:0]       i_op;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_result;
  logic             o_zero;

  modport slave (
    input  i_valid, i_op, i_a, i_b, i_ready,
    output o_ready, o_valid, o_result, o_zero
  );

  modport master (
    output i_valid, i_op, i_a, i_b, i_ready,
    input  o_ready, o_valid, o_result, o_zero
  );
endinterface

`default_nettype wire

// File: rtl/logic_unit_mc.sv
// ============================================================================
// Module  : logic_unit_mc
// Brief   : Bitwise logic unit, single-cycle ops plus iterative CPOP.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module logic_unit_mc #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  wire                  i_clk,
  input  wire                  i_reset,
  logic_unit_mc_if.slave       bus
);

  localparam int N     = WIDTH / CHUNK;
  localparam int ACC_W = $clog2(WIDTH + 1);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [2:0] c_OP_XOR  = 3'b000;
  localparam logic [2:0] c_OP_OR   = 3'b001;
  localparam logic [2:0] c_OP_AND  = 3'b010;
  localparam logic [2:0] c_OP_ZERO = 3'b011;
  localparam logic [2:0] c_OP_XNOR = 3'b100;
  localparam logic [2:0] c_OP_ORN  = 3'b101;
  localparam logic [2:0] c_OP_ANDN = 3'b110;
  localparam logic [2:0] c_OP_CPOP = 3'b111;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_COUNT = 1'b1;

  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;
  logic             r_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic [WIDTH-1:0] r_a;
  logic [ACC_W-1:0] r_acc;
  logic [IDX_W-1:0] r_idx;

  logic             w_ready;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_bit_res;
  logic [ACC_W-1:0] w_chunk_pop;
  logic [ACC_W-1:0] w_acc_next;

  assign w_accept   = bus.i_valid & w_ready;
  assign w_last     = (r_idx == IDX_W'(N - 1));
  assign w_acc_next = r_acc + w_chunk_pop;

  // r_a is shifted right each COUNT cycle, so the active chunk is always the low bits.
  always_comb begin
    w_chunk_pop = '0;
    for (int i = 0; i < CHUNK; i++) begin
      w_chunk_pop = w_chunk_pop + {{(ACC_W-1){1'b0}}, r_a[i]};
    end
  end

  always_comb begin
    w_bit_res = '0;
    case (bus.i_op)
      c_OP_XOR:  w_bit_res = bus.i_a ^ bus.i_b;
      c_OP_OR:   w_bit_res = bus.i_a | bus.i_b;
      c_OP_AND:  w_bit_res = bus.i_a & bus.i_b;
      c_OP_ZERO: w_bit_res = '0;
      c_OP_XNOR: w_bit_res = ~(bus.i_a ^ bus.i_b);
      c_OP_ORN:  w_bit_res = bus.i_a | ~bus.i_b;
      c_OP_ANDN: w_bit_res = bus.i_a & ~bus.i_b;
      default:   w_bit_res = '0;
    endcase
  end

  // FSM: state register
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM: next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && (bus.i_op == c_OP_CPOP)) w_state_nxt = S_COUNT;
      S_COUNT: if (w_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    w_ready      = (r_state == S_IDLE) & (~r_valid | bus.i_ready);
    bus.o_ready  = w_ready;
    bus.o_valid  = r_valid;
    bus.o_result = r_result;
    bus.o_zero   = r_zero;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_valid  <= 1'b0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_a      <= '0;
      r_acc    <= '0;
      r_idx    <= '0;
    end else begin
      if (r_valid && bus.i_ready) begin
        r_valid <= 1'b0;
      end
      if (w_accept) begin
        if (bus.i_op != c_OP_CPOP) begin
          r_result <= w_bit_res;
          r_zero   <= (w_bit_res == '0);
          r_valid  <= 1'b1;
        end else begin
          r_a   <= bus.i_a;
          r_acc <= '0;
          r_idx <= '0;
        end
      end else if (r_state == S_COUNT) begin
        r_a   <= r_a >> CHUNK;
        r_acc <= w_acc_next;
        r_idx <= r_idx + IDX_W'(1);
        if (w_last) begin
          r_result <= {{(WIDTH-ACC_W){1'b0}}, w_acc_next};
          r_zero   <= (w_acc_next == '0);
          r_valid  <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire
